count_arbiter: RTL and testbench
================================

COUNT_ARBITER -- requirements
Module: count_arbiter

Interface
REQ-001 The block SHALL have no parameters; the counter width is fixed at 3 bits and the step-count field at 3 bits.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clock.
REQ-004 req0 / req1  input  1 each  requester 0 / 1 asks for a counting run; held high until done is seen while granted.
REQ-005 dir0 / dir1  input  1 each  run direction: 1 = up, 0 = down; sampled only at grant.
REQ-006 len0 / len1  input  3 each  run length code; run performs len+1 steps (1..8); sampled only at grant.
REQ-007 gnt0 / gnt1  output  1 each  grant to requester 0 / 1; at most one is high at any time.
REQ-008 busy  output  1  high while a run is granted (states RUN and DONE).
REQ-009 done  output  1  single-cycle pulse in the last cycle of a grant.
REQ-010 q  output  3  shared up/down counter value.

Function
REQ-011 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-012 IDLE, no req: stay in IDLE; q holds; gnt0 = gnt1 = busy = done = 0.
REQ-013 IDLE, exactly one req high: on the next edge, grant that requester, latch its dir and len into internal regs, and go to RUN.
REQ-014 IDLE, both req high: grant the requester not served last (round-robin pointer); after reset the pointer favours requester 0.
REQ-015 RUN: each cycle q <= q+1 if latched dir=1, else q-1; the remaining-step counter decrements per step.
REQ-016 RUN: after exactly len+1 steps, go to DONE; q changes on exactly len+1 consecutive edges, starting with the edge that enters RUN+1.
REQ-017 DONE: lasts one cycle, asserts done=1 with the grant still high and q holding, then returns to IDLE.
REQ-018 DONE: the round-robin pointer SHALL be updated to the requester just served.
REQ-019 The grant SHALL be de-asserted on the edge leaving DONE.
REQ-020 A req still high in IDLE after its own DONE is a new request, arbitrated per REQ-014.
REQ-021 Minimum spacing between consecutive grants SHALL be one IDLE cycle.
REQ-022 Changes to req, dir or len of the granted requester during RUN or DONE SHALL be ignored; a req dropped mid-run does not abort the run.
REQ-023 Wrap-around (default build): q arithmetic is modulo 8 (7+1 = 0, 0-1 = 7).
REQ-024 Latency from req high in IDLE to gnt high SHALL be 1 cycle; from grant to done SHALL be len+2 cycles.

Reset
REQ-025 When reset = 0 at a clock edge: state = IDLE, q = 0, gnt0 = gnt1 = busy = done = 0, round-robin pointer favours requester 0, and latched dir/len/step regs = 0.
REQ-026 Reset asserted during RUN or DONE SHALL abort the run immediately, with no done pulse.
REQ-027 Reset SHALL take priority over all other inputs.

Configuration
REQ-028 Macro COUNT_ARB_SATURATE_EN: when defined, q SHALL saturate instead of wrapping. Up-steps at 7 hold at 7; down-steps at 0 hold at 0. The run still takes len+1 cycles and ends with done.
REQ-029 Without COUNT_ARB_SATURATE_EN, behaviour SHALL be the wrap-around behaviour of REQ-023.

Verification
REQ-030 Reset: hold reset = 0 for 2 cycles with req0 = 1 -> q = 0, no gnt, busy = 0.
REQ-031 Single run: after reset, req0 = 1, dir0 = 1, len0 = 2 -> gnt0 1 cycle later, q steps 0,1,2,3, done pulses once, then IDLE.
REQ-032 Contention: req0 = req1 = 1 held continuously, both len = 0 -> grants alternate gnt0, gnt1, gnt0 with one IDLE cycle between them.
REQ-033 Wrap: q = 0, req1 = 1, dir1 = 0, len1 = 1 -> q = 7 then 6, then done. With COUNT_ARB_SATURATE_EN: q stays 0, done still pulses after 2 steps.
REQ-034 Mid-run abort: req0, dir0 = 1, len0 = 7; assert reset after 3 steps -> q = 0, gnt0 = 0, no done.
REQ-035 Input change mid-run: toggle dir0 and len0 during RUN -> step count and direction follow the values latched at grant.

Source files
------------

// File: rtl/count_arbiter.sv
// Two-requester round-robin arbiter that grants a shared 3-bit up/down counter for len+1 steps.
// Optional build macro COUNT_ARB_SATURATE_EN makes the counter saturate at 0/7 instead of wrapping.
module count_arbiter (
   input  logic       clock,
   input  logic       reset,
   input  logic       req0,
   input  logic       req1,
   input  logic       dir0,
   input  logic       dir1,
   input  logic [2:0] len0,
   input  logic [2:0] len1,
   output logic       gnt0,
   output logic       gnt1,
   output logic       busy,
   output logic       done,
   output logic [2:0] q
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic       r_owner;
   logic       r_rr_last;
   logic       r_dir;
   logic [2:0] r_steps;
   logic [2:0] r_q;
   logic       w_grant;
   logic       w_sel;
   logic [2:0] w_q_step;

   always_comb begin
      w_next  = r_state;
      w_grant = 1'b0;
      w_sel   = 1'b0;
      case (r_state)
         IDLE: begin
            if (req0 || req1) begin
               w_grant = 1'b1;
               w_next  = RUN;
               // On contention favour whoever was not served last
               if (req0 && req1) w_sel = ~r_rr_last;
               else              w_sel = req1;
            end
         end
         RUN: begin
            if (r_steps == '0) w_next = DONE;
         end
         DONE: begin
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   always_comb begin
`ifdef COUNT_ARB_SATURATE_EN
      if (r_dir) w_q_step = (r_q == '1) ? r_q : r_q + 3'd1;
      else       w_q_step = (r_q == '0) ? r_q : r_q - 3'd1;
`else
      if (r_dir) w_q_step = r_q + 3'd1;
      else       w_q_step = r_q - 3'd1;
`endif
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_owner   <= 1'b0;
         r_rr_last <= 1'b1;
         r_dir     <= 1'b0;
         r_steps   <= '0;
         r_q       <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            IDLE: begin
               if (w_grant) begin
                  r_owner <= w_sel;
                  r_dir   <= w_sel ? dir1 : dir0;
                  r_steps <= w_sel ? len1 : len0;
               end
            end
            RUN: begin
               r_q <= w_q_step;
               if (r_steps != '0) r_steps <= r_steps - 3'd1;
            end
            DONE: begin
               r_rr_last <= r_owner;
            end
            default: begin
               r_q <= r_q;
            end
         endcase
      end
   end

   always_comb begin
      busy = (r_state != IDLE);
      done = (r_state == DONE);
      gnt0 = busy && !r_owner;
      gnt1 = busy &&  r_owner;
      q    = r_q;
   end

endmodule

// File: tb/tb_count_arbiter.sv
// Self-checking bench for count_arbiter: directed literal cases plus randomized traffic
// compared every cycle against a transaction-level model.
module tb_count_arbiter;

   logic       clock = 1'b0;
   logic       reset;
   logic       req0, req1, dir0, dir1;
   logic [2:0] len0, len1;
   logic       gnt0, gnt1, busy, done;
   logic [2:0] q;

   int errors = 0;
   int checks = 0;

   count_arbiter dut (
      .clock(clock), .reset(reset),
      .req0(req0), .req1(req1), .dir0(dir0), .dir1(dir1),
      .len0(len0), .len1(len1),
      .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .q(q)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Counter value k steps into a run that began at start
   function automatic int qf(input int start, input bit dir, input int k);
      int v;
      v = dir ? start + k : start - k;
`ifdef COUNT_ARB_SATURATE_EN
      if (v > 7) v = 7;
      if (v < 0) v = 0;
`else
      v = ((v % 8) + 8) % 8;
`endif
      return v;
   endfunction

   // Transaction model: a grant lasts len+2 cycles; cycle k of it shows qf(start,dir,min(k,len+1))
   bit m_active = 1'b0;
   bit m_owner  = 1'b0;
   bit m_last   = 1'b1;
   bit m_dir    = 1'b0;
   int m_k      = 0;
   int m_len    = 0;
   int m_start  = 0;
   int m_q      = 0;

   always @(posedge clock) begin
      if (!reset) begin
         m_active = 1'b0;
         m_owner  = 1'b0;
         m_last   = 1'b1;
         m_q      = 0;
      end else if (!m_active) begin
         if (req0 || req1) begin
            m_owner  = (req0 && req1) ? !m_last : req1;
            m_active = 1'b1;
            m_k      = 0;
            m_start  = m_q;
            m_dir    = m_owner ? dir1 : dir0;
            m_len    = m_owner ? int'(len1) : int'(len0);
         end
      end else if (m_k == m_len + 1) begin
         m_active = 1'b0;
         m_last   = m_owner;
         m_q      = qf(m_start, m_dir, m_k);
      end else begin
         m_k++;
      end
   end

   always @(negedge clock) begin
      if ($time > 6) begin
         check("busy", busy, m_active);
         check("gnt0", gnt0, m_active && !m_owner);
         check("gnt1", gnt1, m_active && m_owner);
         check("done", done, m_active && (m_k == m_len + 1));
         check("q", q, m_active ? qf(m_start, m_dir, m_k) : m_q);
      end
   end

   task automatic cyc();
      @(posedge clock);
      #2;
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      req0  = 1'b0;
      req1  = 1'b0;
      cyc();
      reset = 1'b1;
   endtask

   initial begin
      bit ex0 [7] = '{1, 1, 0, 0, 0, 0, 1};
      bit ex1 [7] = '{0, 0, 0, 1, 1, 0, 0};
      reset = 1'b0; req0 = 1'b1; req1 = 1'b0;
      dir0 = 1'b0; dir1 = 1'b0; len0 = '0; len1 = '0;

      // Reset held two cycles with a pending request
      cyc(); cyc();
      check("rst_q", q, 0);
      check("rst_gnt0", gnt0, 0);
      check("rst_busy", busy, 0);

      // Single up run of 3 steps
      dir0 = 1'b1; len0 = 3'd2; reset = 1'b1;
      cyc(); check("run_gnt0", gnt0, 1); check("run_q0", q, 0);
      cyc(); check("run_q1", q, 1);
      cyc(); check("run_q2", q, 2); check("run_nodone", done, 0);
      cyc(); check("run_q3", q, 3); check("run_done", done, 1);
      req0 = 1'b0;
      cyc(); check("run_end_gnt0", gnt0, 0); check("run_end_done", done, 0);

      // Contention with len 0 on both sides
      apply_reset();
      req0 = 1'b1; req1 = 1'b1; len0 = '0; len1 = '0;
      for (int i = 0; i < 7; i++) begin
         cyc();
         check("rr_gnt0", gnt0, ex0[i]);
         check("rr_gnt1", gnt1, ex1[i]);
      end
      req0 = 1'b0; req1 = 1'b0;
      cyc(); cyc(); cyc();

      // Down run from 0
      apply_reset();
      req1 = 1'b1; dir1 = 1'b0; len1 = 3'd1;
      cyc(); check("wrap_gnt1", gnt1, 1); check("wrap_q0", q, 0);
`ifdef COUNT_ARB_SATURATE_EN
      cyc(); check("sat_q1", q, 0);
      cyc(); check("sat_q2", q, 0); check("sat_done", done, 1);
`else
      cyc(); check("wrap_q1", q, 7);
      cyc(); check("wrap_q2", q, 6); check("wrap_done", done, 1);
`endif
      req1 = 1'b0;
      cyc(); check("wrap_end_busy", busy, 0);

      // Reset during a long run
      apply_reset();
      req0 = 1'b1; dir0 = 1'b1; len0 = 3'd7;
      cyc(); cyc(); cyc(); cyc();
      check("abort_pre_q", q, 3);
      reset = 1'b0;
      cyc();
      check("abort_q", q, 0); check("abort_gnt0", gnt0, 0);
      check("abort_done", done, 0); check("abort_busy", busy, 0);
      reset = 1'b1; req0 = 1'b0;
      cyc();

      // Inputs changed after grant must be ignored
      apply_reset();
      req0 = 1'b1; dir0 = 1'b1; len0 = 3'd1;
      cyc(); check("chg_gnt0", gnt0, 1);
      dir0 = 1'b0; len0 = 3'd7; req0 = 1'b0;
      cyc(); check("chg_q1", q, 1);
      cyc(); check("chg_q2", q, 2); check("chg_done", done, 1);
      cyc(); check("chg_busy", busy, 0); check("chg_hold", q, 2);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         reset = ($urandom_range(0, 99) != 0);
         req0  = ($urandom_range(0, 9) < 5);
         req1  = ($urandom_range(0, 9) < 5);
         dir0  = $urandom_range(0, 1) != 0;
         dir1  = $urandom_range(0, 1) != 0;
         len0  = 3'($urandom_range(0, 7));
         len1  = 3'($urandom_range(0, 7));
         cyc();
      end
      reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
      cyc(); cyc();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
